// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT datapath and its controllers.
// The butterfly and every controller take their sizes from here.
package ntt_pkg;

    localparam int unsigned N        = 256;
    localparam int unsigned LOG_N    = 8;
    localparam int unsigned PIPE_LAT = 2;
    localparam logic [15:0] Q        = 16'h1e01;

    localparam int unsigned STAGE_W = $clog2(LOG_N);
    localparam int unsigned K_W     = LOG_N - 1;
    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational (stage, k) -> butterfly operand addresses and bit-reversed zeta index.
// Shared between the forward and inverse NTT controllers.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [K_W-1:0]     k,
    output logic [LOG_N-1:0]   addr_a,
    output logic [LOG_N-1:0]   addr_b,
    output logic [LOG_N-1:0]   zeta_addr
);

    logic [LOG_N-1:0]   k_ext;
    logic [LOG_N-1:0]   len;
    logic [LOG_N-1:0]   grp;
    logic [LOG_N-1:0]   j;
    logic [STAGE_W-1:0] sh;

    always_comb begin
        k_ext     = {1'b0, k};
        // len = 2^sh, so divide/modulo/multiply by len reduce to shifts and masks
        sh        = STAGE_W'(LOG_N - 1) - stage;
        len       = LOG_N'(N / 2) >> stage;
        grp       = k_ext >> sh;
        j         = k_ext & (len - LOG_N'(1));
        addr_a    = ((grp << sh) << 1) + j;
        addr_b    = addr_a + len;
        zeta_addr = (LOG_N'(1) << stage) + grp;
    end

endmodule

// File: rtl/ntt_ctrl.sv
// Forward NTT sequencer: issues N/2 butterflies per stage, drains the pipeline
// between stages, and replays issued addresses PIPE_LAT cycles later as writes.
module ntt_ctrl
    import ntt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] zeta_addr,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    ntt_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [LOG_N-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [LOG_N-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic [LOG_N-1:0]   zeta_addr_q, zeta_addr_d;

    logic [PIPE_LAT-1:0]            wb_valid_q, wb_valid_d;
    logic [PIPE_LAT-1:0][LOG_N-1:0] wb_addr_a_q, wb_addr_a_d;
    logic [PIPE_LAT-1:0][LOG_N-1:0] wb_addr_b_q, wb_addr_b_d;

    logic [LOG_N-1:0] gen_a, gen_b, gen_z;

    // Addresses are generated from the next-cycle counters so they can be
    // registered alongside rd_en and appear in the issue cycle itself.
    ntt_addr_gen u_addr_gen (
        .stage     (stage_d),
        .k         (k_d),
        .addr_a    (gen_a),
        .addr_b    (gen_b),
        .zeta_addr (gen_z)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        drain_d = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (k_q == K_W'(N / 2 - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    if (stage_q == STAGE_W'(LOG_N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + STAGE_W'(1);
                        k_d     = '0;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
        rd_en_d     = (state_d == ST_ISSUE);
        rd_addr_a_d = rd_en_d ? gen_a : '0;
        rd_addr_b_d = rd_en_d ? gen_b : '0;
        zeta_addr_d = rd_en_d ? gen_z : '0;

        wb_valid_d     = wb_valid_q;
        wb_addr_a_d    = wb_addr_a_q;
        wb_addr_b_d    = wb_addr_b_q;
        wb_valid_d[0]  = rd_en_q;
        wb_addr_a_d[0] = rd_addr_a_q;
        wb_addr_b_d[0] = rd_addr_b_q;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            wb_valid_d[i]  = wb_valid_q[i-1];
            wb_addr_a_d[i] = wb_addr_a_q[i-1];
            wb_addr_b_d[i] = wb_addr_b_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            zeta_addr_q <= '0;
            wb_valid_q  <= '0;
            wb_addr_a_q <= '0;
            wb_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            zeta_addr_q <= zeta_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_a_q <= wb_addr_a_d;
            wb_addr_b_q <= wb_addr_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign zeta_addr = zeta_addr_q;
    assign wr_en     = wb_valid_q[PIPE_LAT-1];
    assign wr_addr_a = wb_addr_a_q[PIPE_LAT-1];
    assign wr_addr_b = wb_addr_b_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: cycle-accurate address trace against a scoreboard, plus a
// behavioural RAM/butterfly/zeta ROM whose result is compared with a reference NTT.
module tb_ntt_ctrl;
    import ntt_pkg::*;

    localparam int HALF      = N / 2;
    localparam int STAGE_CYC = HALF + PIPE_LAT;
    localparam int TOTAL     = LOG_N * STAGE_CYC;
    localparam int QI        = int'(Q);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy, done, rd_en, wr_en;
    logic [LOG_N-1:0] rd_addr_a, rd_addr_b, zeta_addr, wr_addr_a, wr_addr_b;

    ntt_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .zeta_addr (zeta_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_a [LOG_N][HALF];
    int exp_b [LOG_N][HALF];
    int exp_z [LOG_N][HALF];
    int zrom   [N];
    int golden [N];
    int ram    [N];
    int ra, rb, rz, bf1, bf2;
    logic load_req;

    typedef struct {
        int cyc;
        int a;
        int b;
    } wb_t;
    wb_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int modpow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % QI;
        return r;
    endfunction

    function automatic int bitrev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < LOG_N; i++) if (x[i]) r |= 1 << (LOG_N - 1 - i);
        return r;
    endfunction

    // Coefficient RAM (read 1 cycle), zeta ROM, and registered butterfly.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) ram[i] <= i % QI;
        end
        if (rd_en) begin
            ra <= ram[rd_addr_a];
            rb <= ram[rd_addr_b];
            rz <= zrom[zeta_addr];
        end
        bf1 <= (ra + (rz * rb) % QI) % QI;
        bf2 <= (ra + QI - (rz * rb) % QI) % QI;
        if (wr_en) begin
            ram[wr_addr_a] <= bf1;
            ram[wr_addr_b] <= bf2;
        end
    end

    task automatic check_idle(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_done"}, done, 0);
            check({tag, "_rd_en"}, rd_en, 0);
            check({tag, "_wr_en"}, wr_en, 0);
            check({tag, "_addr"}, rd_addr_a | rd_addr_b | zeta_addr | wr_addr_a | wr_addr_b, 0);
        end
    endtask

    task automatic kick();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        start    = 1'b1;
    endtask

    // First negedge awaited is C0. restart_at pulses start mid-run; hold keeps
    // start high from the done pulse on so the next call lands on the new C0.
    task automatic run_trace(input int rst_at, input int restart_at, input bit hold);
        int s, i, e_rd, ea, eb, ez, e_wr, wa, wb, bad;
        bit aborted;
        aborted = 1'b0;
        sb.delete();
        for (int cyc = 0; cyc <= TOTAL + 1; cyc++) begin
            @(negedge clk);
            s    = cyc / STAGE_CYC;
            i    = cyc % STAGE_CYC;
            e_rd = (cyc < TOTAL && i < HALF) ? 1 : 0;
            ea = 0; eb = 0; ez = 0;
            if (e_rd != 0) begin
                ea = exp_a[s][i];
                eb = exp_b[s][i];
                ez = exp_z[s][i];
                sb.push_back('{cyc + PIPE_LAT, ea, eb});
            end
            e_wr = 0; wa = 0; wb = 0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e_wr = 1;
                wa   = sb[0].a;
                wb   = sb[0].b;
                void'(sb.pop_front());
            end
            check("busy", busy, (cyc < TOTAL) ? 1 : 0);
            check("done", done, (cyc == TOTAL) ? 1 : 0);
            check("rd_en", rd_en, e_rd);
            check("rd_addr_a", rd_addr_a, ea);
            check("rd_addr_b", rd_addr_b, eb);
            check("zeta_addr", zeta_addr, ez);
            check("wr_en", wr_en, e_wr);
            check("wr_addr_a", wr_addr_a, wa);
            check("wr_addr_b", wr_addr_b, wb);
            if (rd_en && wr_en) begin
                check("raw_hazard",
                      (rd_addr_a == wr_addr_a || rd_addr_a == wr_addr_b ||
                       rd_addr_b == wr_addr_a || rd_addr_b == wr_addr_b) ? 1 : 0, 0);
            end
            case (cyc)
                0:   begin check("s0k0_a", rd_addr_a, 0);   check("s0k0_b", rd_addr_b, 128); check("s0k0_z", zeta_addr, 1);   end
                2:   begin check("first_wr_en", wr_en, 1);  check("first_wr_a", wr_addr_a, 0);  check("first_wr_b", wr_addr_b, 128); end
                127: begin check("s0k127_a", rd_addr_a, 127); check("s0k127_b", rd_addr_b, 255); check("s0k127_z", zeta_addr, 1); end
                130: begin check("s1k0_a", rd_addr_a, 0);   check("s1k0_b", rd_addr_b, 64);  check("s1k0_z", zeta_addr, 2);   end
                194: begin check("s1k64_a", rd_addr_a, 128); check("s1k64_b", rd_addr_b, 192); check("s1k64_z", zeta_addr, 3); end
                915: begin check("s7k5_a", rd_addr_a, 10);  check("s7k5_b", rd_addr_b, 11);  check("s7k5_z", zeta_addr, 133); end
                default: ;
            endcase
            if (cyc == TOTAL) begin
                bad = 0;
                for (int n = 0; n < N; n++) if (ram[n] != golden[n]) bad++;
                check("ntt_coeff_mismatches", bad, 0);
            end
            start    = (cyc == restart_at) || (hold && cyc >= TOTAL);
            load_req = hold && (cyc == TOTAL);
            if (cyc == rst_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            check_idle("in_rst", 3);
            rst = 1'b0;
            check_idle("after_rst", 5);
        end
    endtask

    initial begin
        int len, idx, kz, t;
        for (int s = 0; s < LOG_N; s++) begin
            len = N >> (s + 1);
            idx = 0;
            for (int st = 0; st < N; st += 2 * len) begin
                for (int j = 0; j < len; j++) begin
                    exp_a[s][idx] = st + j;
                    exp_b[s][idx] = st + j + len;
                    exp_z[s][idx] = (1 << s) + st / (2 * len);
                    idx++;
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            zrom[n]   = modpow(62, bitrev(n));
            golden[n] = n % QI;
        end
        kz = 1;
        for (len = HALF; len >= 1; len = len >> 1) begin
            for (int st = 0; st < N; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    t               = (zrom[kz] * golden[j + len]) % QI;
                    golden[j + len] = (golden[j] + QI - t) % QI;
                    golden[j]       = (golden[j] + t) % QI;
                end
                kz++;
            end
        end

        rst      = 1'b1;
        start    = 1'b0;
        load_req = 1'b0;
        check_idle("reset", 3);
        rst = 1'b0;
        check_idle("idle", 3);

        kick();
        run_trace(-1, -1, 1'b0);
        check_idle("post_run1", 3);

        kick();
        run_trace(-1, 500, 1'b1);
        run_trace(-1, -1, 1'b0);
        check_idle("post_chain", 3);

        kick();
        run_trace(300, -1, 1'b0);

        kick();
        run_trace(-1, -1, 1'b0);
        check_idle("final", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
